// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential floating-point divider.
package fp_div_pkg;

  // Controller states; the encoding is fixed so waveforms read the same across builds.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIV    = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Bit positions inside the 5-bit exception flag word.
  localparam int FLAG_W = 5;
  localparam int FLG_NV = 4;  // invalid operation
  localparam int FLG_DZ = 3;  // division by zero
  localparam int FLG_OF = 2;  // overflow
  localparam int FLG_UF = 1;  // underflow
  localparam int FLG_NX = 0;  // inexact

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier. Exponent zero is treated as zero, so
// denormals are flushed before they reach the divider.
module fp_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_f,
  input  logic [MAN_W-1:0] frac,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  logic exp_ones;
  logic frac_zero;

  assign exp_ones  = &exp_f;
  assign frac_zero = ~|frac;

  assign is_zero = ~|exp_f;
  assign is_inf  = exp_ones & frac_zero;
  assign is_nan  = exp_ones & ~frac_zero;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: res = n / x using a radix-2 restoring
// mantissa divider (one quotient bit per cycle) and round-to-nearest-even.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       r_i,
  input  logic [EXP_W+MAN_W:0]       n,
  input  logic [EXP_W+MAN_W:0]       x,
  output logic [EXP_W+MAN_W:0]       res,
  output logic [FLAG_W-1:0]          flags,
  output logic                       r_o,
  output logic                       busy
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int ITERS = MAN_W + 3;          // quotient bits produced
  localparam int CNT_W = $clog2(ITERS);
  localparam int QW    = MAN_W + 3;          // quotient width, MSB has weight 1
  localparam int RW    = MAN_W + 2;          // partial remainder width
  localparam int E_W   = EXP_W + 2;          // signed exponent work width

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [W-1:0]     n_q, x_q;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    rem;
  logic [QW-1:0]    quo;

  // Operand fields
  logic             sign_q;
  logic [EXP_W-1:0] exp_n, exp_x;
  logic [MAN_W-1:0] frac_n, frac_x;

  assign sign_q = n_q[W-1] ^ x_q[W-1];
  assign exp_n  = n_q[W-2:MAN_W];
  assign exp_x  = x_q[W-2:MAN_W];
  assign frac_n = n_q[MAN_W-1:0];
  assign frac_x = x_q[MAN_W-1:0];

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic zero_n, inf_n, nan_n;
  logic zero_x, inf_x, nan_x;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_n (
    .exp_f   (exp_n),
    .frac    (frac_n),
    .is_zero (zero_n),
    .is_inf  (inf_n),
    .is_nan  (nan_n)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
    .exp_f   (exp_x),
    .frac    (frac_x),
    .is_zero (zero_x),
    .is_inf  (inf_x),
    .is_nan  (nan_x)
  );

  // ---------------------------------------------------------------------------
  // Special-operand result, decided in UNPACK
  // ---------------------------------------------------------------------------
  logic              special;
  logic [W-1:0]      spec_res;
  logic [FLAG_W-1:0] spec_flags;

  // Select the fixed result for NaN/inf/zero operand combinations.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    special    = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (nan_n || nan_x || (zero_n && zero_x) || (inf_n && inf_x)) begin
      spec_res           = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags[FLG_NV] = 1'b1;
    end else if (inf_n) begin
      spec_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_x) begin
      spec_res           = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags[FLG_DZ] = 1'b1;
    end else if (inf_x || zero_n) begin
      spec_res = {sign_q, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------------
  logic [RW-1:0] div_b;
  logic [RW-1:0] rem_sel;
  logic [RW-1:0] rem_nxt;
  logic          rem_ge;

  assign div_b = {1'b0, 1'b1, frac_x};

  // Subtract the divisor when it fits, then shift the remainder for the next bit.
  // The remainder stays below twice the divisor, so the shift never loses a bit.
  always_comb begin
    rem_ge  = (rem >= div_b);
    rem_sel = rem_ge ? (rem - div_b) : rem;
    rem_nxt = rem_sel << 1;
  end

  // ---------------------------------------------------------------------------
  // Normalise, round to nearest even, range check
  // ---------------------------------------------------------------------------
  logic                  norm;
  logic [QW-1:0]         qn;
  logic [MAN_W:0]        man;
  logic                  guard, sticky, round_up, carry;
  logic [MAN_W+1:0]      man_r;
  logic [MAN_W-1:0]      frac_r;
  logic signed [E_W-1:0] e_rnd;
  logic [W-1:0]          rnd_res;
  logic [FLAG_W-1:0]     rnd_flags;

  // Build the final packed result and flags from quotient, remainder and exponents.
  always_comb begin
    norm      = ~quo[QW-1];
    qn        = norm ? {quo[QW-2:0], 1'b0} : quo;
    man       = qn[QW-1:2];
    guard     = qn[1];
    sticky    = qn[0] | (|rem);
    round_up  = guard & (sticky | man[0]);
    man_r     = {1'b0, man} + {{(MAN_W+1){1'b0}}, round_up};
    carry     = man_r[MAN_W+1];
    frac_r    = carry ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    e_rnd     = $signed({2'b00, exp_n}) - $signed({2'b00, exp_x})
              + $signed(E_W'(BIAS)) - $signed(E_W'(norm)) + $signed(E_W'(carry));
    rnd_res   = {sign_q, e_rnd[EXP_W-1:0], frac_r};
    rnd_flags = '0;
    rnd_flags[FLG_NX] = guard | sticky;
    if (e_rnd >= $signed(E_W'(2**EXP_W - 1))) begin
      rnd_res           = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags[FLG_OF] = 1'b1;
      rnd_flags[FLG_NX] = 1'b1;
    end else if (e_rnd <= $signed(E_W'(0))) begin
      rnd_res           = {sign_q, {(W-1){1'b0}}};
      rnd_flags[FLG_UF] = 1'b1;
      rnd_flags[FLG_NX] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    r_o       = 1'b0;
    case (state)
      S_IDLE:   if (r_i) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = special ? S_DONE : S_DIV;
      S_DIV:    if (cnt == CNT_W'(ITERS - 1)) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE: begin
        r_o       = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate the divider, load the result on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q   <= '0;
      x_q   <= '0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      res   <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (r_i) begin
            n_q <= n;
            x_q <= x;
          end
        end
        S_UNPACK: begin
          rem <= {1'b0, 1'b1, frac_n};
          quo <= '0;
          cnt <= '0;
          if (special) begin
            res   <= spec_res;
            flags <= spec_flags;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= {quo[QW-2:0], rem_ge};
          cnt <= cnt + CNT_W'(1);
        end
        S_ROUND: begin
          res   <= rnd_res;
          flags <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: a single-precision instance and a
// half-precision (EXP_W=5, MAN_W=10) instance share one driver task.
module tb_fp_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // Single precision instance
  logic        r_i;
  logic [31:0] n, x, res;
  logic [4:0]  flags;
  logic        r_o, busy;

  // Half precision instance
  logic        h_r_i;
  logic [15:0] h_n, h_x, h_res;
  logic [4:0]  h_flags;
  logic        h_r_o, h_busy;

  fp_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .r_i   (r_i),
    .n     (n),
    .x     (x),
    .res   (res),
    .flags (flags),
    .r_o   (r_o),
    .busy  (busy)
  );

  fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk   (clk),
    .rst_n (rst_n),
    .r_i   (h_r_i),
    .n     (h_n),
    .x     (h_x),
    .res   (h_res),
    .flags (h_flags),
    .r_o   (h_r_o),
    .busy  (h_busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   sel_h  = 1'b0;

  logic        cur_ro, cur_busy;
  logic [31:0] cur_res;
  logic [4:0]  cur_flags;

  assign cur_ro    = sel_h ? h_r_o    : r_o;
  assign cur_busy  = sel_h ? h_busy   : busy;
  assign cur_res   = sel_h ? {16'h0, h_res} : res;
  assign cur_flags = sel_h ? h_flags  : flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  // Push the expectation, start one operation, then wait (bounded) for r_o and
  // compare. A non-zero inj re-pulses r_i with other operands after edge inj.
  task automatic run_op(input string tag, input bit half,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [4:0] ef,
                        input int lat, input int inj);
    exp_t e;
    int   edges;
    int   busy_low;
    sb.push_back('{er, ef, lat});
    sel_h = half;
    @(negedge clk);
    if (half) begin
      h_n = a[15:0]; h_x = b[15:0]; h_r_i = 1'b1;
    end else begin
      n = a; x = b; r_i = 1'b1;
    end
    @(posedge clk);  // edge 0
    #1;
    r_i = 1'b0; h_r_i = 1'b0;
    edges = 0;
    busy_low = 0;
    while (!cur_ro && edges < 200) begin
      if (!cur_busy) busy_low++;
      if (inj > 0 && edges == inj) begin
        n = 32'h3F800000; x = 32'h40400000; r_i = 1'b1;
      end else begin
        r_i = 1'b0;
      end
      @(posedge clk);
      edges++;
      #1;
    end
    r_i = 1'b0;
    e = sb.pop_front();
    check({tag, "_latency"}, edges, e.lat);
    check({tag, "_res"}, cur_res, e.res);
    check({tag, "_flags"}, {27'h0, cur_flags}, {27'h0, e.flags});
    check({tag, "_busy_held"}, busy_low, 0);
    check({tag, "_busy_done"}, {31'h0, cur_busy}, 32'd1);
    @(posedge clk);  // DONE -> IDLE
    #1;
    check({tag, "_ro_pulse"}, {31'h0, cur_ro}, 32'd0);
    check({tag, "_idle"}, {31'h0, cur_busy}, 32'd0);
    check({tag, "_res_hold"}, cur_res, e.res);
  endtask

  initial begin
    rst_n = 1'b0;
    r_i = 1'b0; n = '0; x = '0;
    h_r_i = 1'b0; h_n = '0; h_x = '0;
    #1;
    check("rst_res",   res, 32'h0);
    check("rst_flags", {27'h0, flags}, 32'h0);
    check("rst_ro",    {31'h0, r_o}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal operands
    run_op("div_6_2",   1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 0);
    run_op("div_1_3",   1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 0);
    run_op("div_1_1p5", 1'b0, 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 5'b00001, 28, 0);
    run_op("div_m6_2",  1'b0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28, 0);

    // Special operands
    run_op("one_zero",  1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1, 0);
    run_op("mone_zero", 1'b0, 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 1, 0);
    run_op("zero_zero", 1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1, 0);
    run_op("inf_inf",   1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1, 0);
    run_op("nan_one",   1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1, 0);
    run_op("inf_two",   1'b0, 32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1, 0);
    run_op("mtwo_inf",  1'b0, 32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 1, 0);

    // Range limits
    run_op("overflow",  1'b0, 32'h7F000000, 32'h3F000000, 32'h7F800000, 5'b00101, 28, 0);
    run_op("underflow", 1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28, 0);

    // r_i while busy is ignored: the original 6/2 result comes back
    run_op("ignore_ri", 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 5);

    // Result to be wiped by reset
    run_op("pre_rst",   1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 0);

    // Asynchronous reset in the middle of DIV
    @(negedge clk);
    n = 32'h40C00000; x = 32'h40000000; r_i = 1'b1;
    @(posedge clk);
    #1;
    r_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'h0, busy}, 32'h0);
    check("arst_ro",    {31'h0, r_o}, 32'h0);
    check("arst_res",   res, 32'h0);
    check("arst_flags", {27'h0, flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst",  1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 0);

    // Half precision instance
    run_op("h_6_2",     1'b1, 32'h4600, 32'h4000, 32'h4200, 5'b00000, 15, 0);
    run_op("h_1_zero",  1'b1, 32'h3C00, 32'h0000, 32'h7C00, 5'b01000, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
